fetch_prefetch: RTL and testbench

Instruction prefetch unit upstream of the pipelined core's decode stage. It replaces the zero-latency instruction memory lookup with a request/response memory port. It issues sequential word fetches ahead of the core and buffers returned instructions, with their PCs, in a small in-order queue. On a control-flow redirect from the core it flushes the queue and discards any responses still in flight.

---
 rtl/fetch_prefetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 63 ++++++
 rtl/fetch_prefetch.sv | 107 ++++++++++
 tb/tb_fetch_prefetch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: the NOP used on an
// empty output, the default reset PC and the queue entry layout.
package fetch_prefetch_pkg;

  localparam logic [31:0] NOP_INS          = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h00000003;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of {pc, ins} entries. Flush wins over push and pop; the head
// entry is presented combinationally so decode sees it in the same cycle.
module fetch_queue
  import fetch_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t  entries_reg [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign head    = entries_reg[rd_ptr_reg];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset: only slots below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) entries_reg[wr_ptr_reg] <= push_data;
  end

  // The credit rule upstream guarantees a free slot for every response.
  always_ff @(posedge clk) begin
    if (!rst && do_push) assert (count_reg != FULL_COUNT);
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: issues sequential word fetches ahead of decode,
// buffers returned instructions with their PCs, and on a redirect flushes the
// buffer and discards every response still in flight.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [CW-1:0] drop_reg, drop_next;

  logic [CW-1:0] q_count;
  logic          q_empty;
  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;
  logic          q_push;
  logic          q_pop;

  logic          req_accept;
  logic          resp_keep;
  logic [CW:0]   credit_used;

  // Outstanding requests plus buffered entries may never exceed DEPTH, so
  // every response is guaranteed a queue slot.
  assign credit_used   = {1'b0, inflight_reg} + {1'b0, q_count};
  assign mem_req_valid = !rst && (credit_used < CREDITS);
  assign mem_req_addr  = fetch_pc_reg;
  assign req_accept    = mem_req_valid && mem_req_ready;

  // A response is kept only when nothing is pending discard and no redirect
  // is flushing the stream this cycle.
  assign resp_keep        = mem_resp_valid && (drop_reg == '0) && !redirect;
  assign q_push           = resp_keep;
  assign q_pop            = ins_valid && !stall && !redirect;
  assign q_push_data.pc   = resp_pc_reg;
  assign q_push_data.ins  = mem_resp_data;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .pop      (q_pop),
    .flush    (redirect),
    .push_data(q_push_data),
    .head     (q_head),
    .count    (q_count),
    .empty    (q_empty)
  );

  assign ins_valid = !q_empty;
  assign ins       = ins_valid ? q_head.ins : NOP_INS;
  assign ins_pc    = ins_valid ? q_head.pc  : 32'h0;

  // Next-state for PCs and counters; a redirect overrides the normal updates
  // and marks every request still outstanding (including one accepted now)
  // for discard.
  always_comb begin
    inflight_next = inflight_reg + CW'(req_accept) - CW'(mem_resp_valid);
    fetch_pc_next = req_accept ? fetch_pc_reg + 32'd4 : fetch_pc_reg;
    resp_pc_next  = resp_keep  ? resp_pc_reg + 32'd4  : resp_pc_reg;
    drop_next     = (mem_resp_valid && (drop_reg != '0)) ? drop_reg - 1'b1 : drop_reg;
    if (redirect) begin
      fetch_pc_next = word_align(redirect_pc);
      resp_pc_next  = word_align(redirect_pc);
      drop_next     = inflight_next;
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      resp_pc_reg  <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      resp_pc_reg  <= resp_pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with an in-order memory model of
// configurable latency. Memory returns data = address + 0x10000000.
module tb_fetch_prefetch;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;

  int n_chk = 0;
  int n_bad = 0;

  fetch_prefetch #(
    .DEPTH   (4),
    .RESET_PC(32'h00000000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .ins_valid     (ins_valid),
    .ins           (ins),
    .ins_pc        (ins_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  pend_t       pe;
  int          lat = 1;
  int          cyc = 0;
  logic        acc_seen = 1'b0;
  logic [31:0] acc_addr = 32'h0;

  // Handshake is stable mid-cycle; record it for the coming edge.
  always @(negedge clk) begin
    acc_seen = !rst && mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
  end

  // Memory is reset together with the prefetcher.
  always @(posedge rst) begin
    pend.delete();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (rst) begin
      pend.delete();
    end else begin
      if (mem_resp_valid && pend.size() > 0) pend.delete(0);
      if (acc_seen) begin
        pe.addr = acc_addr;
        pe.due  = cyc + lat - 1;
        pend.push_back(pe);
      end
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = pend[0].addr + 32'h10000000;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset(input int l, input logic rdy, input logic stl);
    rst           = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    lat           = l;
    mem_req_ready = rdy;
    stall         = stl;
    go();
    go();
    go();
    rst = 1'b0;
  endtask

  logic [31:0] exp_pc [5];

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    mem_req_ready = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    stall         = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_ins_valid", 32'(ins_valid), 32'h0);
    chk("rst_ins_nop", ins, 32'h00000013);
    chk("rst_ins_pc", ins_pc, 32'h0);

    // ready held low: request held with stable address
    do_reset(1, 1'b0, 1'b0);
    smp();
    chk("rdylo_valid_c1", 32'(mem_req_valid), 32'h1);
    chk("rdylo_addr_c1", mem_req_addr, 32'h0);
    for (int k = 2; k <= 5; k++) begin
      go();
      smp();
      chk($sformatf("rdylo_valid_c%0d", k), 32'(mem_req_valid), 32'h1);
      chk($sformatf("rdylo_addr_c%0d", k), mem_req_addr, 32'h0);
    end
    go();
    mem_req_ready = 1'b1;
    smp();
    chk("rdyhi_addr", mem_req_addr, 32'h0);
    go();
    smp();
    chk("rdyhi_next_addr", mem_req_addr, 32'h4);
    chk("rdyhi_ins_valid0", 32'(ins_valid), 32'h0);
    go();
    smp();
    chk("rdyhi_ins_valid1", 32'(ins_valid), 32'h1);
    chk("rdyhi_ins_pc", ins_pc, 32'h0);

    // asynchronous reset mid-stream, checked between clock edges
    go();
    rst = 1'b1;
    #1;
    chk("midrst_req_valid", 32'(mem_req_valid), 32'h0);
    chk("midrst_ins_valid", 32'(ins_valid), 32'h0);
    chk("midrst_ins_nop", ins, 32'h00000013);
    chk("midrst_ins_pc", ins_pc, 32'h0);

    // 1-cycle memory streaming after reset
    do_reset(1, 1'b1, 1'b0);
    smp();
    chk("strm_valid_c1", 32'(mem_req_valid), 32'h1);
    chk("strm_addr_c1", mem_req_addr, 32'h0);
    go();
    smp();
    chk("strm_addr_c2", mem_req_addr, 32'h4);
    chk("strm_ins_valid_c2", 32'(ins_valid), 32'h0);
    go();
    smp();
    chk("strm_ins_valid_c3", 32'(ins_valid), 32'h1);
    chk("strm_ins_pc_c3", ins_pc, 32'h0);
    chk("strm_ins_c3", ins, 32'h10000000);
    go();
    smp();
    chk("strm_ins_pc_c4", ins_pc, 32'h4);
    go();
    smp();
    chk("strm_ins_pc_c5", ins_pc, 32'h8);
    chk("strm_ins_c5", ins, 32'h10000008);

    // redirect coinciding with response arrival and request acceptance
    go();
    redirect    = 1'b1;
    redirect_pc = 32'h00000203;
    smp();
    chk("rdco_pre_valid", 32'(ins_valid), 32'h1);
    chk("rdco_pre_pc", ins_pc, 32'hC);
    go();
    redirect = 1'b0;
    smp();
    chk("rdco_n1_ins_valid", 32'(ins_valid), 32'h0);
    chk("rdco_n1_addr", mem_req_addr, 32'h200);
    chk("rdco_n1_req_valid", 32'(mem_req_valid), 32'h1);
    go();
    smp();
    chk("rdco_n2_ins_valid", 32'(ins_valid), 32'h0);
    chk("rdco_n2_addr", mem_req_addr, 32'h204);
    go();
    smp();
    chk("rdco_n3_ins_valid", 32'(ins_valid), 32'h1);
    chk("rdco_n3_ins_pc", ins_pc, 32'h200);
    chk("rdco_n3_ins", ins, 32'h10000200);
    go();
    smp();
    chk("rdco_n4_ins_pc", ins_pc, 32'h204);

    // redirect near the top of the address space: fetch wraps to 0
    go();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFFFFFB;
    smp();
    go();
    redirect = 1'b0;
    smp();
    chk("wrap_n1_ins_valid", 32'(ins_valid), 32'h0);
    chk("wrap_n1_addr", mem_req_addr, 32'hFFFFFFF8);
    go();
    smp();
    chk("wrap_n2_addr", mem_req_addr, 32'hFFFFFFFC);
    go();
    smp();
    chk("wrap_n3_addr", mem_req_addr, 32'h0);
    chk("wrap_n3_ins_pc", ins_pc, 32'hFFFFFFF8);
    chk("wrap_n3_ins", ins, 32'h0FFFFFF8);
    go();
    smp();
    chk("wrap_n4_ins_pc", ins_pc, 32'hFFFFFFFC);
    go();
    smp();
    chk("wrap_n5_ins_pc", ins_pc, 32'h0);
    chk("wrap_n5_ins", ins, 32'h10000000);

    // stall with 2-cycle memory: credits run out, then drain in order
    do_reset(2, 1'b1, 1'b1);
    smp();
    chk("stall_addr_c1", mem_req_addr, 32'h0);
    for (int k = 2; k <= 10; k++) begin
      go();
      smp();
      if (k >= 5) chk($sformatf("stall_req_valid_c%0d", k), 32'(mem_req_valid), 32'h0);
    end
    chk("stall_head_valid", 32'(ins_valid), 32'h1);
    chk("stall_head_pc", ins_pc, 32'h0);
    exp_pc[0] = 32'h0;
    exp_pc[1] = 32'h4;
    exp_pc[2] = 32'h8;
    exp_pc[3] = 32'hC;
    exp_pc[4] = 32'h10;
    go();
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) go();
      smp();
      chk($sformatf("drain_valid_%0d", k), 32'(ins_valid), 32'h1);
      chk($sformatf("drain_pc_%0d", k), ins_pc, exp_pc[k]);
      chk($sformatf("drain_ins_%0d", k), ins, exp_pc[k] + 32'h10000000);
    end

    // redirect to 0x103 with three requests outstanding (5-cycle memory)
    do_reset(5, 1'b1, 1'b0);
    smp();
    chk("rd3_addr_c1", mem_req_addr, 32'h0);
    go();
    smp();
    go();
    smp();
    chk("rd3_addr_c3", mem_req_addr, 32'h8);
    go();
    mem_req_ready = 1'b0;
    redirect      = 1'b1;
    redirect_pc   = 32'h00000103;
    smp();
    go();
    redirect      = 1'b0;
    mem_req_ready = 1'b1;
    smp();
    chk("rd3_n1_ins_valid", 32'(ins_valid), 32'h0);
    chk("rd3_n1_req_valid", 32'(mem_req_valid), 32'h1);
    chk("rd3_n1_addr", mem_req_addr, 32'h100);
    for (int k = 1; k <= 6; k++) begin
      go();
      smp();
      chk($sformatf("rd3_wait_valid_%0d", k), 32'(ins_valid), (k == 6) ? 32'h1 : 32'h0);
    end
    chk("rd3_first_pc", ins_pc, 32'h100);
    chk("rd3_first_ins", ins, 32'h10000100);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
